reg_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one simple register access port between NUM_REQ internal requesters.
- Typical requesters: the AXI-Lite register slave, a QSFP I2C sequencer and a debug/init engine.
- Serialises the requests into single pulsed register accesses on one downstream register file.
- Returns read data and a one-cycle acknowledge to the requester that was granted.

---
 rtl/reg_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_reg_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Round-robin arbiter that shares one register access port between
//   NUM_REQ internal requesters. Each grant becomes one single-cycle read or
//   write pulse on the register file. The requester then gets a one-cycle
//   acknowledge, with read data valid in that same cycle.
//
// Handshake: a requester raises req_valid[i] with stable we/addr/wdata/wstrb
//   and holds it until req_ack[i] pulses. If req_valid[i] is still high in the
//   IDLE cycle after the ack, that is treated as a new request. Once an access
//   is captured it completes even if req_valid drops early.
//
// Ports
//   s_axi_aclk, s_axi_areset   clock, async active-high reset
//   req_valid/req_we           per-requester request level and direction
//   req_addr/wdata/wstrb       flattened fields; requester i at [i*W +: W]
//   req_ack                    one-hot completion pulse
//   req_rdata                  shared read data, valid in the ack cycle
//   m_wr_en/m_rd_en            single-cycle access pulses to the register file
//   m_addr/m_wdata/m_wstrb     registered access fields, held between accesses
//   m_rdata                    register file read data, RD_LATENCY after m_rd_en
//   busy                       high whenever the FSM is not IDLE
//   grant_idx                  current or most recent grant
//   dbg_state                  FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
module reg_bus_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                                  s_axi_aclk,
  input  logic                                  s_axi_areset,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_REQ*AXI_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]                    req_ack,
  output logic [AXI_DATA_WIDTH-1:0]             req_rdata,
  output logic                                  m_wr_en,
  output logic                                  m_rd_en,
  output logic [AXI_ADDR_WIDTH-1:0]             m_addr,
  output logic [AXI_DATA_WIDTH-1:0]             m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]           m_wstrb,
  input  logic [AXI_DATA_WIDTH-1:0]             m_rdata,
  output logic                                  busy,
  output logic [$clog2(NUM_REQ)-1:0]            grant_idx,
  output logic [1:0]                            dbg_state
);

  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [GW-1:0] ptr;
  logic [3:0]    wait_cnt;
  logic          is_write;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Unpack the flattened request fields.
  logic [AW-1:0] addr_a  [NUM_REQ];
  logic [DW-1:0] wdata_a [NUM_REQ];
  logic [SW-1:0] wstrb_a [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*AW +: AW];
      wdata_a[i] = req_wdata[i*DW +: DW];
      wstrb_a[i] = req_wstrb[i*SW +: SW];
    end
  end

  // Round-robin select. Rotate the request vector so that the pointer sits at
  // bit 0. The lowest set bit is then the offset of the winner from the
  // pointer. Adding that offset back to the pointer, modulo NUM_REQ, gives
  // the winner's index.
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 any_req;
  logic [GW:0]          off;
  logic [GW:0]          sum;
  logic [GW-1:0]        sel;

  always_comb begin
    dbl     = {req_valid, req_valid} >> ptr;
    rot     = dbl[NUM_REQ-1:0];
    any_req = |rot;
    off     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = (GW+1)'(k);
    end
    sum = {1'b0, ptr} + off;
    if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
    sel = sum[GW-1:0];
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      wait_cnt  <= '0;
      is_write  <= 1'b0;
      grant_idx <= '0;
      req_ack   <= '0;
      req_rdata <= '0;
      m_wr_en   <= 1'b0;
      m_rd_en   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_wstrb   <= '0;
    end else begin
      // Pulses default low so each is exactly one cycle wide.
      m_wr_en <= 1'b0;
      m_rd_en <= 1'b0;
      req_ack <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant_idx <= sel;
            is_write  <= req_we[sel];
            m_addr    <= addr_a[sel];
            m_wdata   <= wdata_a[sel];
            m_wstrb   <= wstrb_a[sel];
            m_wr_en   <= req_we[sel];
            m_rd_en   <= ~req_we[sel];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (is_write) begin
            req_ack <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            state   <= ST_DONE;
          end else if (RD_LATENCY == 0) begin
            // A zero-latency register file returns data in the pulse cycle.
            req_rdata <= m_rdata;
            req_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= 4'(RD_LATENCY - 1);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            req_rdata <= m_rdata;
            req_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
            state     <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ST_DONE: begin
          // The requester after the one just served gets top priority next.
          ptr   <= (grant_idx == GW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter
//   Bench for reg_bus_arbiter. The main DUT runs with RD_LATENCY=3, and a
//   second instance runs with RD_LATENCY=0 for the zero-latency read corner.
//   The behavioural model tracks grants as events on a cycle timeline:
//   grant cycle T, pulse at T+1, ack at T+2 (+latency for reads).
//   A compare process checks every main-DUT output against that model on
//   every negative edge. Directed sections pin the model with literal
//   expectations.
module tb_reg_bus_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int GW  = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (RD_LATENCY = 3) ----------------
  logic [N-1:0]    req_valid, req_we, req_ack;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   req_rdata, m_wdata, m_rdata;
  logic [AW-1:0]   m_addr;
  logic [SW-1:0]   m_wstrb;
  logic            m_wr_en, m_rd_en, busy;
  logic [GW-1:0]   grant_idx;
  logic [1:0]      dbg_state;

  reg_bus_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                    .RD_LATENCY(LAT)) dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ack(req_ack),
    .req_rdata(req_rdata), .m_wr_en(m_wr_en), .m_rd_en(m_rd_en),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .busy(busy), .grant_idx(grant_idx),
    .dbg_state(dbg_state)
  );

  // ---------------- zero-latency DUT ----------------
  logic [N-1:0]    z_req_valid, z_req_we, z_req_ack;
  logic [N*AW-1:0] z_req_addr;
  logic [N*DW-1:0] z_req_wdata;
  logic [N*SW-1:0] z_req_wstrb;
  logic [DW-1:0]   z_req_rdata, z_m_wdata, z_m_rdata;
  logic [AW-1:0]   z_m_addr;
  logic [SW-1:0]   z_m_wstrb;
  logic            z_m_wr_en, z_m_rd_en, z_busy;
  logic [GW-1:0]   z_grant_idx;
  logic [1:0]      z_dbg_state;

  reg_bus_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
                    .RD_LATENCY(0)) dut_z (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .req_valid(z_req_valid), .req_we(z_req_we), .req_addr(z_req_addr),
    .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb), .req_ack(z_req_ack),
    .req_rdata(z_req_rdata), .m_wr_en(z_m_wr_en), .m_rd_en(z_m_rd_en),
    .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_wstrb(z_m_wstrb),
    .m_rdata(z_m_rdata), .busy(z_busy), .grant_idx(z_grant_idx),
    .dbg_state(z_dbg_state)
  );

  // Register file contents, as seen by both DUTs.
  function automatic logic [DW-1:0] rf_data(input logic [AW-1:0] a);
    if (a == 32'h20) return 32'h12345678;
    return (a * 32'h9E3779B1) ^ 32'h0F0F5A5A;
  endfunction

  // Read data is valid only in the cycle exactly LAT cycles after the pulse.
  logic [LAT:1]  rd_sh = '0;
  logic [AW-1:0] a_sh [1:LAT];
  always @(posedge clk) begin
    rd_sh <= {rd_sh[LAT-1:1], m_rd_en};
    a_sh[1] <= m_addr;
    for (int k = 2; k <= LAT; k++) a_sh[k] <= a_sh[k-1];
  end
  assign m_rdata   = rd_sh[LAT] ? rf_data(a_sh[LAT]) : 32'hBAD0BAD0;
  assign z_m_rdata = z_m_rd_en ? rf_data(z_m_addr) : 32'hBAD0BAD0;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  int            ptr_m = 0, free_at = 0, g_cyc = 0, ack_cyc = 0, g_idx = 0;
  bit            has_g = 0, g_we = 0;
  logic [AW-1:0] g_addr, exp_addr;
  logic [DW-1:0] g_wdata, exp_wdata, exp_rdata;
  logic [SW-1:0] g_wstrb, exp_wstrb;
  int            exp_grant;
  logic [DW-1:0] exp_rdata_q [$];

  always @(negedge clk) begin
    logic          e_wr, e_rd, e_busy;
    logic [N-1:0]  e_ack;
    bit            found;
    if (rst) begin
      ptr_m = 0; has_g = 0; free_at = 0;
      exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_rdata = '0; exp_grant = 0;
      exp_rdata_q.delete();
    end else if (has_g && cyc == g_cyc + 1) begin
      exp_addr = g_addr; exp_wdata = g_wdata; exp_wstrb = g_wstrb; exp_grant = g_idx;
    end
    e_wr   = !rst && has_g && cyc == g_cyc + 1 && g_we;
    e_rd   = !rst && has_g && cyc == g_cyc + 1 && !g_we;
    e_ack  = (!rst && has_g && cyc == ack_cyc) ? N'(1) << g_idx : '0;
    e_busy = !rst && has_g && cyc > g_cyc && cyc <= ack_cyc;
    if (!rst && has_g && cyc == ack_cyc && !g_we) exp_rdata = exp_rdata_q.pop_front();
    check("wr_en", m_wr_en, e_wr);
    check("rd_en", m_rd_en, e_rd);
    check("ack", req_ack, e_ack);
    check("busy", busy, e_busy);
    check("grant_idx", grant_idx, exp_grant);
    check("m_addr", m_addr, exp_addr);
    check("m_wdata", m_wdata, exp_wdata);
    check("m_wstrb", m_wstrb, exp_wstrb);
    check("req_rdata", req_rdata, exp_rdata);
    // Grant decision for the edge that closes this cycle.
    if (!rst && cyc >= free_at && req_valid != '0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (ptr_m + k) % N;
        if (!found && req_valid[i]) begin
          found = 1;
          has_g = 1; g_cyc = cyc; g_idx = i; g_we = req_we[i];
          g_addr = req_addr[i*AW +: AW]; g_wdata = req_wdata[i*DW +: DW];
          g_wstrb = req_wstrb[i*SW +: SW];
          ack_cyc = cyc + 2 + (g_we ? 0 : LAT);
          free_at = ack_cyc + 1;
          ptr_m = (i + 1) % N;
          if (!g_we) exp_rdata_q.push_back(rf_data(g_addr));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_valid[i] = 1'b1; req_we[i] = we;
    req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic set_req_rand(input int i);
    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 255) * 4),
            $urandom, SW'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  logic [N-1:0] seen_ack = '0;

  task automatic run_random(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (seen_ack[i]) begin
          if ($urandom_range(0, 1) == 1) set_req_rand(i);
          else clr_req(i);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req_rand(i);
        end
      end
      seen_ack = req_ack;
    end
  endtask

  // ---------------- main sequence ----------------
  int         n_got;
  int         order [8];
  bit         ok;
  logic [1:0] wr_seen;

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    z_req_valid = '0; z_req_we = '0; z_req_addr = '0; z_req_wdata = '0; z_req_wstrb = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", req_ack, 0);
    check("rst_wr_rd", {m_wr_en, m_rd_en}, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_grant", grant_idx, 0);
    rst = 1'b0;

    // Single write from requester 2, then wrap-around 3 before 0.
    tick();
    set_req(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    check("wr1_pulse", {m_wr_en, m_rd_en}, 2'b10);
    check("wr1_addr", m_addr, 32'h10);
    check("wr1_wdata", m_wdata, 32'hDEADBEEF);
    check("wr1_grant", grant_idx, 2);
    check("wr1_no_ack", req_ack, 0);
    tick();
    check("wr1_ack", req_ack, 4'b0100);
    check("wr1_pulse_gone", m_wr_en, 0);
    tick();
    clr_req(2);
    set_req(0, 1'b1, 32'h30, 32'h0BADF00D, 4'h3);
    set_req(3, 1'b1, 32'h40, 32'hCAFEF00D, 4'hC);
    tick();
    check("wrap_first", grant_idx, 3);
    check("wrap_first_addr", m_addr, 32'h40);
    tick();
    check("wrap_first_ack", req_ack, 4'b1000);
    tick();
    clr_req(3);
    tick();
    check("wrap_second", grant_idx, 0);
    check("wrap_second_wstrb", m_wstrb, 4'h3);
    tick();
    check("wrap_second_ack", req_ack, 4'b0001);
    tick();

    // Read of 0x20 by requester 0 with three-cycle latency.
    set_req(0, 1'b0, 32'h20, 32'h0, 4'h0);
    wr_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (m_wr_en) wr_seen = 1;
      if (k == 1) begin
        check("rd_pulse", {m_wr_en, m_rd_en}, 2'b01);
        check("rd_addr", m_addr, 32'h20);
      end
      if (k >= 2 && k <= 4) check("rd_ack_early", req_ack, 0);
      if (k == 5) begin
        check("rd_ack", req_ack, 4'b0001);
        check("rd_data", req_rdata, 32'h12345678);
      end
    end
    check("rd_no_wr", wr_seen, 0);
    clr_req(0);

    // Contention: all four held continuously for eight accesses.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(32'h100 + 4 * i), DW'(32'h11111111 * i), 4'hF);
    n_got = 0;
    for (int c = 0; c < 80 && n_got < 8; c++) begin
      tick();
      if (m_wr_en) begin order[n_got] = grant_idx; n_got++; end
    end
    req_valid = '0;
    check("cont_count", n_got, 8);
    for (int j = 0; j < 8; j++) check("cont_order", order[j], j % 4);
    repeat (4) tick();

    // Reset during WAIT aborts the read; pointer returns to 0.
    set_req(2, 1'b0, 32'h20, 32'h0, 4'h0);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin tick(); ok = req_ack[2]; end
    check("abort_pre_ack", ok, 1);
    tick();
    clr_req(2);
    set_req(1, 1'b0, 32'h60, 32'h0, 4'h0);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin tick(); ok = m_rd_en; end
    check("abort_pulse", ok, 1);
    tick();
    check("abort_in_wait", dbg_state, 2);
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_grant", grant_idx, 0);
    check("abort_rdata", req_rdata, 0);
    check("abort_fields", {m_addr, m_wstrb}, 0);
    check("abort_pulses", {req_ack, m_wr_en, m_rd_en}, 0);
    req_valid = '0;
    tick(); tick();
    rst = 1'b0;
    ok = 1;
    for (int c = 0; c < 8; c++) begin tick(); if (req_ack != 0) ok = 0; end
    check("abort_no_ack", ok, 1);
    set_req(0, 1'b1, 32'h70, 32'h77, 4'h1);
    set_req(3, 1'b1, 32'h74, 32'h74, 4'h8);
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin tick(); ok = m_wr_en; end
    check("post_rst_prio", {ok, 6'(grant_idx)}, {1'b1, 6'd0});
    req_valid = '0;
    repeat (6) tick();

    // Zero-latency instance: read ack and data at T+2, same as a write.
    z_req_valid[1] = 1'b1; z_req_we[1] = 1'b0; z_req_addr[1*AW +: AW] = 32'h20;
    tick();
    check("z_rd_pulse", {z_m_wr_en, z_m_rd_en}, 2'b01);
    tick();
    check("z_rd_ack", z_req_ack, 4'b0010);
    check("z_rd_data", z_req_rdata, 32'h12345678);
    tick();
    z_req_valid[1] = 1'b0;
    z_req_valid[2] = 1'b1; z_req_we[2] = 1'b1; z_req_addr[2*AW +: AW] = 32'h44;
    tick();
    check("z_wr_pulse", {z_m_wr_en, z_m_rd_en}, 2'b10);
    tick();
    check("z_wr_ack", z_req_ack, 4'b0100);
    check("z_wr_keeps_rdata", z_req_rdata, 32'h12345678);
    tick();
    z_req_valid[2] = 1'b0;

    // Randomized traffic checked against the model, then drain.
    seen_ack = '0;
    run_random(2000);
    for (int c = 0; c < 200 && (req_valid != 0 || busy); c++) begin
      tick();
      for (int i = 0; i < N; i++) if (seen_ack[i]) clr_req(i);
      seen_ack = req_ack;
    end
    check("drain_idle", {req_valid, busy}, 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
